// File: rtl/inst_buffer_drain.sv
// -----------------------------------------------------------------------------
// inst_buffer_drain
//
// Consumer end of the instruction buffer, sitting between the buffer and
// rename. Each cycle it decides whether the 4-wide bundle at the buffer head
// is taken, drives the buffer's stall input, latches the accepted bundle into
// a pipeline register for rename, and tracks free branch checkpoints so a
// bundle is only accepted when every branch in it can get a tag.
//
// Ports:
//   clk                  clock
//   reset                synchronous, active-high reset
//   flush_i              control-mispredict flush
//   instBufferReady_i    buffer holds at least DISPATCH_WIDTH instructions
//   decodedPacket0..3_i  head bundle from the buffer
//   branchCount_i        number of branches in the head bundle
//   backendStall_i       rename/IQ/active list cannot accept this cycle
//   resolveCount_i       checkpoints freed this cycle
//   stall_o              buffer stall; 1 means the head is not taken
//   renameReady_o        output bundle register is valid
//   decodedPacket0..3_o  latched bundle
//   branchCount_o        branch count of the latched bundle
//   freeTags_o           current free checkpoint count
//   tagOverflow_o        sticky error: resolves pushed the count past MAX_BRANCH
// -----------------------------------------------------------------------------
module inst_buffer_drain #(
  parameter int PACKET_W       = 128,
  parameter int DISPATCH_WIDTH = 4,
  parameter int MAX_BRANCH     = 8,
  parameter int TAG_W          = 4,
  parameter int BC_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                instBufferReady_i,
  input  logic [PACKET_W-1:0] decodedPacket0_i,
  input  logic [PACKET_W-1:0] decodedPacket1_i,
  input  logic [PACKET_W-1:0] decodedPacket2_i,
  input  logic [PACKET_W-1:0] decodedPacket3_i,
  input  logic [BC_W-1:0]     branchCount_i,
  input  logic                backendStall_i,
  input  logic [BC_W-1:0]     resolveCount_i,
  output logic                stall_o,
  output logic                renameReady_o,
  output logic [PACKET_W-1:0] decodedPacket0_o,
  output logic [PACKET_W-1:0] decodedPacket1_o,
  output logic [PACKET_W-1:0] decodedPacket2_o,
  output logic [PACKET_W-1:0] decodedPacket3_o,
  output logic [BC_W-1:0]     branchCount_o,
  output logic [TAG_W-1:0]    freeTags_o,
  output logic                tagOverflow_o
);

  localparam logic [TAG_W-1:0] MaxTags     = TAG_W'(MAX_BRANCH);
  localparam logic [TAG_W:0]   MaxTagsWide = (TAG_W+1)'(MAX_BRANCH);

  logic [PACKET_W-1:0] packetIn [DISPATCH_WIDTH];
  logic [PACKET_W-1:0] packetQ  [DISPATCH_WIDTH];

  logic             consume;
  logic             holdFull;
  logic             tagShort;
  logic             load;
  logic [TAG_W-1:0] branchCountExt;
  logic [TAG_W-1:0] resolveCountExt;
  logic [TAG_W:0]   tagTaken;
  logic [TAG_W:0]   tagNext;
  logic             tagClamp;

  assign packetIn[0] = decodedPacket0_i;
  assign packetIn[1] = decodedPacket1_i;
  assign packetIn[2] = decodedPacket2_i;
  assign packetIn[3] = decodedPacket3_i;

  assign decodedPacket0_o = packetQ[0];
  assign decodedPacket1_o = packetQ[1];
  assign decodedPacket2_o = packetQ[2];
  assign decodedPacket3_o = packetQ[3];

  assign branchCountExt  = TAG_W'(branchCount_i);
  assign resolveCountExt = TAG_W'(resolveCount_i);

  // Handshake. A full register with a stalled backend blocks the head; so does
  // a bundle with more branches than there are free checkpoints right now.
  assign consume  = renameReady_o & ~backendStall_i;
  assign holdFull = renameReady_o & backendStall_i;
  assign tagShort = branchCountExt > freeTags_o;
  assign stall_o  = reset | flush_i | holdFull | tagShort;
  assign load     = instBufferReady_i & ~stall_o;

  // Next free-tag count, one bit wider so an excess of resolves is visible.
  // The subtraction cannot wrap: load already implies ~tagShort.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    tagTaken = '0;
    if (load) tagTaken = {1'b0, branchCountExt};
    tagNext  = {1'b0, freeTags_o} - tagTaken + {1'b0, resolveCountExt};
  end

  assign tagClamp = tagNext > MaxTagsWide;

  // Output bundle register. A consume and a load in the same cycle simply
  // replace the contents, keeping renameReady_o high for full throughput.
  // A flush invalidates the bundle but leaves the stale packets in place.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      renameReady_o <= 1'b0;
      branchCount_o <= '0;
      // NOTE: the packet holders are ordinary flops rather than a memory array,
      // so they are reset along with the valid bit.
      for (int i = 0; i < DISPATCH_WIDTH; i++) packetQ[i] <= '0;
    end else if (flush_i) begin
      renameReady_o <= 1'b0;
    end else if (load) begin
      renameReady_o <= 1'b1;
      branchCount_o <= branchCount_i;
      for (int i = 0; i < DISPATCH_WIDTH; i++) packetQ[i] <= packetIn[i];
    end else if (consume) begin
      renameReady_o <= 1'b0;
    end
  end

  // Free checkpoint counter. A flush returns every checkpoint and ignores
  // that cycle's resolves; the overflow flag survives flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      freeTags_o    <= MaxTags;
      tagOverflow_o <= 1'b0;
    end else if (flush_i) begin
      freeTags_o    <= MaxTags;
    end else if (tagClamp) begin
      freeTags_o    <= MaxTags;
      tagOverflow_o <= 1'b1;
    end else begin
      freeTags_o    <= tagNext[TAG_W-1:0];
    end
  end

endmodule

// File: tb/tb_inst_buffer_drain.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer_drain
//
// Self-checking bench for inst_buffer_drain. A small behavioural model tracks
// the expected valid bit, free-tag count and overflow flag; every accepted
// bundle is pushed to a scoreboard queue and popped and compared when rename
// consumes it. Directed sequences walk the handshake and tag corner cases,
// followed by a randomized phase with flushes and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_inst_buffer_drain;

  typedef struct packed {
    logic [3:0][127:0] pkts;
    logic [2:0]        bc;
  } bundle_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         ibr;
  logic [3:0][127:0] pin;
  logic [2:0]   bc;
  logic         bstall;
  logic [2:0]   res;
  logic         stall;
  logic         ready;
  logic [127:0] pout0, pout1, pout2, pout3;
  logic [2:0]   bcOut;
  logic [3:0]   freeTags;
  logic         tagOvf;

  inst_buffer_drain dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush),
    .instBufferReady_i (ibr),
    .decodedPacket0_i  (pin[0]),
    .decodedPacket1_i  (pin[1]),
    .decodedPacket2_i  (pin[2]),
    .decodedPacket3_i  (pin[3]),
    .branchCount_i     (bc),
    .backendStall_i    (bstall),
    .resolveCount_i    (res),
    .stall_o           (stall),
    .renameReady_o     (ready),
    .decodedPacket0_o  (pout0),
    .decodedPacket1_o  (pout1),
    .decodedPacket2_o  (pout2),
    .decodedPacket3_o  (pout3),
    .branchCount_o     (bcOut),
    .freeTags_o        (freeTags),
    .tagOverflow_o     (tagOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrs   = 0;

  // Model state
  logic       mReady = 1'b0;
  logic [3:0] mFree  = 4'd8;
  logic       mOvf   = 1'b0;
  bundle_t    sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic newPackets();
    for (int i = 0; i < 4; i++) pin[i] = rnd128();
  endtask

  // One clock cycle: inputs are already set (after a negedge). Checks the
  // combinational stall, pops/compares a consumed bundle, advances the model
  // at the posedge and checks the registered outputs at the next negedge.
  task automatic tick();
    logic    expStall, expLoad, expConsume;
    logic [4:0] sum;
    bundle_t e;
    #1;
    expStall   = reset | flush | (mReady & bstall) | ({1'b0, bc} > mFree);
    expLoad    = ibr & ~expStall;
    expConsume = mReady & ~bstall;
    check("stall", stall, expStall);
    if (!reset && !flush && expConsume) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pkt0", pout0, e.pkts[0]);
        check("pkt1", pout1, e.pkts[1]);
        check("pkt2", pout2, e.pkts[2]);
        check("pkt3", pout3, e.pkts[3]);
        check("bc_out", bcOut, e.bc);
      end
    end
    @(posedge clk);
    if (reset) begin
      mReady = 1'b0; mFree = 4'd8; mOvf = 1'b0; sb.delete();
    end else if (flush) begin
      mReady = 1'b0; mFree = 4'd8; sb.delete();
    end else begin
      if (expLoad) begin
        e.pkts = pin; e.bc = bc;
        sb.push_back(e);
      end
      mReady = expLoad ? 1'b1 : (expConsume ? 1'b0 : mReady);
      sum = {1'b0, mFree} - (expLoad ? {2'b0, bc} : 5'd0) + {2'b0, res};
      if (sum > 5'd8) begin
        mFree = 4'd8; mOvf = 1'b1;
      end else begin
        mFree = sum[3:0];
      end
    end
    @(negedge clk);
    check("ready", ready, mReady);
    check("free_tags", freeTags, mFree);
    check("tag_ovf", tagOvf, mOvf);
  endtask

  task automatic drive(input logic i_ibr, input logic [2:0] i_bc,
                       input logic i_bstall, input logic [2:0] i_res);
    ibr = i_ibr; bc = i_bc; bstall = i_bstall; res = i_res;
    newPackets();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ibr = 1'b0; bc = '0; bstall = 1'b0; res = '0;
    newPackets();
    @(negedge clk);

    // Reset state
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_pkt0", pout0, 0);
    check("rst_pkt3", pout3, 0);
    check("rst_bc", bcOut, 0);
    check("rst_free", freeTags, 8);
    check("rst_ovf", tagOvf, 0);
    reset = 1'b0;

    // 1: streaming one branch per bundle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd1, 1'b0, 3'd0);
      #1 check("tp1_stall", stall, 0);
      tick();
      check("tp1_ready", ready, 1);
      check("tp1_free", freeTags, 7 - i);
    end

    // 2: backend stall holds the register, then back-to-back release
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 1'b1, 3'd0);
      #1 check("tp2_stall", stall, 1);
      tick();
      if (sb.size() > 0) check("tp2_hold", pout0, sb[0].pkts[0]);
    end
    drive(1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    check("tp2_ready", ready, 1);
    check("tp2_free", freeTags, 2);

    // 3: tag shortage blocks, resolve frees, then load to zero
    drive(1'b1, 3'd3, 1'b0, 3'd0);
    #1 check("tp3_stall", stall, 1);
    tick();
    check("tp3_free_a", freeTags, 2);
    drive(1'b1, 3'd3, 1'b0, 3'd1);
    tick();
    check("tp3_free_b", freeTags, 3);
    drive(1'b1, 3'd3, 1'b0, 3'd0);
    #1 check("tp3_stall_c", stall, 0);
    tick();
    check("tp3_free_c", freeTags, 0);

    // 4: load and resolve together
    drive(1'b0, 3'd0, 1'b0, 3'd2);
    tick();
    drive(1'b1, 3'd2, 1'b0, 3'd4);
    tick();
    check("tp4_free", freeTags, 4);

    // 5: overflow clamps and sticks
    drive(1'b0, 3'd0, 1'b0, 3'd3);
    tick();
    check("tp5_free_a", freeTags, 7);
    drive(1'b0, 3'd0, 1'b0, 3'd3);
    tick();
    check("tp5_free_b", freeTags, 8);
    check("tp5_ovf", tagOvf, 1);

    // 6: flush while valid with 3 free tags
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    check("tp6_pre_free", freeTags, 3);
    check("tp6_pre_ready", ready, 1);
    drive(1'b1, 3'd2, 1'b0, 3'd2);
    flush = 1'b1;
    #1 check("tp6_stall", stall, 1);
    tick();
    flush = 1'b0;
    check("tp6_ready", ready, 0);
    check("tp6_free", freeTags, 8);
    check("tp6_ovf", tagOvf, 1);
    drive(1'b1, 3'd2, 1'b0, 3'd0);
    tick();
    check("tp6_reload", ready, 1);
    check("tp6_free_b", freeTags, 6);

    // Randomized traffic with occasional flushes and a mid-stream reset
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 9) < 8, 3'($urandom_range(0, 4)),
            $urandom_range(0, 9) < 3,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 3)) : 3'd0);
      flush = ($urandom_range(0, 14) == 0);
      reset = (i == 40);
      tick();
    end
    reset = 1'b0; flush = 1'b0;

    // Drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    check("drain_sb", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrs);
    $finish;
  end

endmodule

// File: doc/inst_buffer_drain.md
Name: inst_buffer_drain

Overview:
- Consumer end of the instruction buffer, between it and rename.
- Decides each cycle whether the 4-wide dispatch bundle at the buffer head is taken, and drives the buffer's stall input.
- Latches the accepted bundle into a pipeline register for rename.
- Tracks free branch checkpoints so a bundle is never accepted unless all its branches can get a tag.

Parameters:
- PACKET_W, 128, width of one decoded packet (buffer entry width).
- DISPATCH_WIDTH, 4, packets per bundle (fixed at 4; ports are unrolled).
- MAX_BRANCH, 8, number of branch checkpoints/tags in the machine.
- TAG_W, 4, width of the free-tag counter; must hold MAX_BRANCH.
- BC_W, 3, width of per-cycle branch counts (0..DISPATCH_WIDTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  control-mispredict flush.
- instBufferReady_i  in  1  buffer holds at least DISPATCH_WIDTH instructions.
- decodedPacket0_i..decodedPacket3_i  in  PACKET_W each  head bundle from the buffer.
- branchCount_i  in  BC_W  number of branches in the head bundle.
- backendStall_i  in  1  rename/issue queue/active list cannot accept this cycle.
- resolveCount_i  in  BC_W  checkpoints freed this cycle (branch resolve/commit).
- stall_o  out  1  drives the buffer's stall input; 1 means the head is not taken.
- renameReady_o  out  1  output bundle register is valid.
- decodedPacket0_o..decodedPacket3_o  out  PACKET_W each  latched bundle.
- branchCount_o  out  BC_W  branch count of the latched bundle.
- freeTags_o  out  TAG_W  current free checkpoint count.
- tagOverflow_o  out  1  sticky error: resolves exceeded MAX_BRANCH.

Behaviour:
- Reset (synchronous, active-high) values: renameReady_o=0, packets_o=0, branchCount_o=0, freeTags_o=MAX_BRANCH, tagOverflow_o=0.
- Signals:
  - consume = renameReady_o & ~backendStall_i
  - holdFull = renameReady_o & backendStall_i
  - tagShort = branchCount_i > freeTags_o (unsigned, current registered value)
- stall_o = reset | flush_i | holdFull | tagShort. Purely combinational, no added latency.
- load = instBufferReady_i & ~stall_o. The buffer advances its head in exactly the cycles where load=1.
- Output register:
  - On load: capture packets_i and branchCount_i; renameReady_o<=1 next cycle. Latency is 1 cycle, buffer head to rename.
  - Else if consume: renameReady_o<=0.
  - Else: hold all fields.
  - Back-to-back: a consume and a load in the same cycle replace the register; renameReady_o stays 1. Full throughput is 1 bundle/cycle.
- Free-tag counter:
  - next = freeTags_o - (load ? branchCount_i : 0) + resolveCount_i, computed TAG_W+1 bits wide.
  - If next > MAX_BRANCH: clamp to MAX_BRANCH and set tagOverflow_o (sticky until reset).
  - Subtraction never underflows, because load implies ~tagShort.
  - Simultaneous load and resolve in one cycle: both apply.
  - branchCount_i == freeTags_o is allowed (counter reaches 0).
- Flush:
  - renameReady_o<=0 and freeTags_o<=MAX_BRANCH.
  - resolveCount_i is ignored that cycle.
  - packets_o keep their values but are invalid.
  - tagOverflow_o is unaffected.
- Reset mid-bundle discards the latched bundle with no further handshake. Reset has priority over flush.
- Packets and branch count pass through unmodified; no decode inside the block.

Test Plan:
1. Reset, then instBufferReady_i=1, branchCount_i=1, backendStall_i=0 for 5 cycles -> stall_o=0 throughout; renameReady_o=1 from cycle 2; freeTags_o steps 8,7,6,5,4,3.
2. Bundle latched, then backendStall_i=1 for 3 cycles with instBufferReady_i=1 -> stall_o=1 for those 3 cycles; packets_o unchanged; on release, consume and new load occur in the same cycle and renameReady_o stays 1.
3. freeTags_o=2, branchCount_i=3 -> stall_o=1, no load; resolveCount_i=1 next cycle -> freeTags_o=3, then load occurs and freeTags_o=0.
4. freeTags_o=2, load with branchCount_i=2 and resolveCount_i=4 in the same cycle -> freeTags_o=4.
5. freeTags_o=7, resolveCount_i=3 -> freeTags_o=8 (clamped), tagOverflow_o=1 and it stays set through a later flush.
6. flush_i=1 while renameReady_o=1 and freeTags_o=3 -> stall_o=1 that cycle; next cycle renameReady_o=0 and freeTags_o=8; a load proceeds normally the cycle after.
